// File: rtl/spiker_writer_pkg.sv
// Shared types, defaults and helpers for the spiker frame writer.
// Sizing helpers and the popcount used by the SPIKER_WRITER_POPCOUNT_EN build.
package spiker_writer_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 800;
    localparam int unsigned POP_MAX_W      = 4096;

    function automatic int unsigned n_words(
        input int unsigned data_w,
        input int unsigned word_w
    );
        return (data_w + word_w - 1) / word_w;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned popcount(
        input logic [POP_MAX_W-1:0] v
    );
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c += {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/spiker_frame_fifo.sv
// DEPTH x DATA_WIDTH frame store with wrap-around pointers and a level count.
// Callers gate push/pop with full/empty; clear flushes pointers and level.
module spiker_frame_fifo
    import spiker_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PW        = ptr_w(DEPTH),
    localparam int unsigned LW        = lvl_w(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [LW-1:0]         level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [LW-1:0]         level_q;

    // Frame storage; no reset, stale frames are unreachable once pointers reset
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i && !rst_i) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and level bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      level_q <= level_q + LW'(1);
            else if (pop_i && !push_i) level_q <= level_q - LW'(1);
        end
    end

    assign head_o  = mem[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/spiker_frame_writer.sv
// Buffers core spike frames and pops them onto word-sliced result registers.
// Optional popcount output enabled by defining SPIKER_WRITER_POPCOUNT_EN.
module spiker_frame_writer
    import spiker_writer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SAMPLE_DIV_W = 4,
    localparam int unsigned N_REG       = n_words(DATA_WIDTH, WORD_WIDTH),
    localparam int unsigned RW          = N_REG * WORD_WIDTH,
    localparam int unsigned LW          = lvl_w(DEPTH),
    localparam int unsigned CW          = $clog2(DATA_WIDTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    valid_i,
    output logic                    writer_ready_o,
    input  logic                    sample_i,
    input  logic [SAMPLE_DIV_W-1:0] sample_div_i,
    input  logic                    clear_i,
    output logic [RW-1:0]           result_o,
    output logic                    result_valid_o,
    output logic                    status_ready_o,
    output logic                    status_sample_o,
    output logic [LW-1:0]           level_o,
    output logic                    overflow_o,
    output logic                    underflow_o,
    output logic [CW-1:0]           spike_count_o
);

    logic [DATA_WIDTH-1:0]   head;
    logic                    full;
    logic                    empty;
    logic                    push_ok;
    logic                    pop_ok;
    logic [RW-1:0]           head_pad;
    logic [RW-1:0]           result_q;
    logic                    rvalid_q;
    logic                    ssample_q;
    logic                    ovf_q;
    logic                    unf_q;
    logic [SAMPLE_DIV_W-1:0] cnt_q;

    assign push_ok = valid_i && !full && !clear_i;
    assign pop_ok  = sample_i && !empty && !clear_i;

    spiker_frame_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(clear_i),
        .push_i (push_ok),
        .pop_i  (pop_ok),
        .data_i (data_i),
        .head_o (head),
        .level_o(level_o),
        .full_o (full),
        .empty_o(empty)
    );

    // Zero-pad the head frame up to the full register word span
    always_comb begin
        head_pad = '0;
        head_pad[DATA_WIDTH-1:0] = head;
    end

    // Pop register, sample divider and sticky status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            ssample_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cnt_q     <= '0;
        end else if (clear_i) begin
            rvalid_q  <= 1'b0;
            ssample_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rvalid_q  <= pop_ok;
            ssample_q <= 1'b0;
            if (valid_i && full) ovf_q <= 1'b1;
            if (sample_i && empty) unf_q <= 1'b1;
            if (pop_ok) begin
                result_q <= head_pad;
                if (cnt_q >= sample_div_i) begin
                    cnt_q     <= '0;
                    ssample_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + SAMPLE_DIV_W'(1);
                end
            end
        end
    end

`ifdef SPIKER_WRITER_POPCOUNT_EN
    logic [POP_MAX_W-1:0] head_ext;
    logic [CW-1:0]        count_q;

    always_comb begin
        head_ext = '0;
        head_ext[DATA_WIDTH-1:0] = head;
    end

    // Popcount captured together with the popped frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (pop_ok) begin
            count_q <= CW'(popcount(head_ext));
        end
    end

    assign spike_count_o = count_q;
`else
    assign spike_count_o = '0;
`endif

    assign writer_ready_o  = !full;
    assign status_ready_o  = valid_i;
    assign result_o        = result_q;
    assign result_valid_o  = rvalid_q;
    assign status_sample_o = ssample_q;
    assign overflow_o      = ovf_q;
    assign underflow_o     = unf_q;

endmodule

// File: tb/tb_spiker_frame_writer.sv
// Randomised and directed bench for spiker_frame_writer (784-bit frames).
// Reference model keeps frames in a queue and applies the pop/push rules.
module tb_spiker_frame_writer;

    localparam int WW  = 32;
    localparam int DW  = 784;
    localparam int DEP = 4;
    localparam int SDW = 4;
    localparam int NR  = (DW + WW - 1) / WW;
    localparam int RW  = NR * WW;
    localparam int LW  = $clog2(DEP + 1);
    localparam int CW  = $clog2(DW + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [DW-1:0]  data;
    logic           valid;
    logic           wready;
    logic           sample;
    logic [SDW-1:0] div;
    logic           clear;
    logic [RW-1:0]  result;
    logic           rvalid;
    logic           sready;
    logic           ssample;
    logic [LW-1:0]  level;
    logic           ovf;
    logic           unf;
    logic [CW-1:0]  scount;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic [RW-1:0] m_res;
    int            m_cnt;
    bit            m_ovf, m_unf, m_rv, m_ss;
    int            m_sc;
    int            pulse_pops[$];
    int            pop_no;

    always #5 clk = ~clk;

    spiker_frame_writer #(
        .WORD_WIDTH  (WW),
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .SAMPLE_DIV_W(SDW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data),
        .valid_i        (valid),
        .writer_ready_o (wready),
        .sample_i       (sample),
        .sample_div_i   (div),
        .clear_i        (clear),
        .result_o       (result),
        .result_valid_o (rvalid),
        .status_ready_o (sready),
        .status_sample_o(ssample),
        .level_o        (level),
        .overflow_o     (ovf),
        .underflow_o    (unf),
        .spike_count_o  (scount)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_frame();
        logic [RW-1:0] r;
        for (int i = 0; i < NR; i++) r[i*WW +: WW] = $urandom;
        return r[DW-1:0];
    endfunction

    // Model: applies one clock edge's worth of rules to the frame queue
    task automatic model_step();
        bit had_room, had_frame;
        logic [DW-1:0] f;
        m_rv = 0;
        m_ss = 0;
        if (rst) begin
            q.delete();
            m_res = '0; m_sc = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else if (clear) begin
            q.delete();
            m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            had_room  = q.size() < DEP;
            had_frame = q.size() > 0;
            if (sample) begin
                if (had_frame) begin
                    f = q.pop_front();
                    m_res = {{(RW-DW){1'b0}}, f};
`ifdef SPIKER_WRITER_POPCOUNT_EN
                    m_sc = $countones(f);
`else
                    m_sc = 0;
`endif
                    m_rv = 1;
                    pop_no++;
                    if (m_cnt >= int'(div)) begin
                        m_cnt = 0;
                        m_ss = 1;
                        pulse_pops.push_back(pop_no);
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_unf = 1;
                end
            end
            if (valid) begin
                if (had_room) q.push_back(data);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NR; i++)
            check($sformatf("result_w%0d", i), 64'(result[i*WW +: WW]),
                  64'(m_res[i*WW +: WW]));
        check("result_valid", 64'(rvalid), 64'(m_rv));
        check("status_sample", 64'(ssample), 64'(m_ss));
        check("level", 64'(level), 64'(q.size()));
        check("writer_ready", 64'(wready), 64'(q.size() != DEP));
        check("overflow", 64'(ovf), 64'(m_ovf));
        check("underflow", 64'(unf), 64'(m_unf));
        check("spike_count", 64'(scount), 64'(m_sc));
    endtask

    task automatic cycle(input bit r, input bit v, input bit s,
                         input bit c, input logic [DW-1:0] d);
        rst = r; valid = v; sample = s; clear = c; data = d;
        #1;
        check("status_ready", 64'(sready), 64'(v));
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    logic [DW-1:0] ones;
    logic [DW-1:0] ends;

    initial begin
        rst = 1; valid = 0; sample = 0; clear = 0; data = '0; div = '0;
        m_res = '0; m_cnt = 0; m_sc = 0; m_ovf = 0; m_unf = 0;
        pop_no = 0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 0, '0);

        // Fill to DEPTH, then drain in order
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, rand_frame());
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, '0);

        // Overflow on fifth push, drain, clear
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, rand_frame());
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 0, 1, '0);

        // Empty pop, then push and pop together on empty
        cycle(0, 0, 1, 0, '0);
        cycle(0, 1, 1, 0, rand_frame());
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 0, 1, '0);

        // Divide by 15 over 30 pops
        div = 4'd14;
        pulse_pops.delete();
        pop_no = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(0, 1, 0, 0, rand_frame());
            cycle(0, 0, 1, 0, '0);
        end
        check("div15_pulses", 64'(pulse_pops.size()), 64'd2);
        if (pulse_pops.size() == 2) begin
            check("div15_first", 64'(pulse_pops[0]), 64'd15);
            check("div15_second", 64'(pulse_pops[1]), 64'd30);
        end

        // Divide by 1: pulse on every pop, including push+pop overlap
        div = 4'd0;
        cycle(0, 1, 0, 0, rand_frame());
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, rand_frame());
        cycle(0, 0, 1, 0, '0);

        // Popcount extremes and zero-padded top word
        ones = '1;
        ends = '0;
        ends[0] = 1'b1;
        ends[DW-1] = 1'b1;
        cycle(0, 1, 0, 0, ones);
        cycle(0, 1, 1, 0, ends);
        cycle(0, 0, 1, 0, '0);

        // Divider lowered below the running count
        div = 4'd9;
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, rand_frame());
        div = 4'd1;
        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, '0);

        // Random traffic with occasional clear, reset and divider changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) div = SDW'($urandom_range(0, 15));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 59) == 0,
                  rand_frame());
        end
        cycle(1, 0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spiker_frame_writer.md
# spiker_frame_writer

Parametrised frame writer between the spiking core output and the adapter register file. Each completed spike frame from the core is stored in a DEPTH-frame FIFO. Host sample strobes pop one frame per strobe onto word-sliced result registers. A programmable sample divider replaces the fixed divide-by-15 status pulse, and sticky overflow/underflow flags plus a fill level are exported for status registers.

## Interface
Parameters:
- WORD_WIDTH, 32, register word width
- DATA_WIDTH, 800, spike frame width from the core
- DEPTH, 4, frames buffered (power of two, ≥2)
- SAMPLE_DIV_W, 4, width of divider setting
- N_REG (localparam), ceil(DATA_WIDTH/WORD_WIDTH) = 25, result words

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- data_i  in  DATA_WIDTH  spike frame from core
- valid_i  in  1  core frame-ready strobe
- writer_ready_o  out  1  FIFO can accept a frame
- sample_i  in  1  host sample strobe (pop request)
- sample_div_i  in  SAMPLE_DIV_W  status pulse every sample_div_i+1 successful pops
- clear_i  in  1  synchronous flush
- result_o  out  N_REG*WORD_WIDTH  popped frame, word i = bits [(i+1)*WORD_WIDTH-1 -: WORD_WIDTH]
- result_valid_o  out  1  one-cycle pulse per successful pop
- status_ready_o  out  1  combinational mirror of valid_i
- status_sample_o  out  1  one-cycle divided sample pulse
- level_o  out  $clog2(DEPTH+1)  frames stored
- overflow_o  out  1  sticky, frame dropped
- underflow_o  out  1  sticky, pop on empty
- spike_count_o  out  $clog2(DATA_WIDTH+1)  popcount of popped frame (see Configuration)

## Operation
- Push: valid_i && writer_ready_o at an edge writes data_i at the write pointer; level +1.
- Drop: valid_i && !writer_ready_o discards the frame and sets overflow_o.
- Pop: sample_i && level!=0 loads result_o from the head and pulses result_valid_o; level −1.
- Empty pop: sample_i && level==0 sets underflow_o. result_o holds, no pulse, divider is not advanced.
- No bypass: a push and a pop in the same cycle on an empty FIFO. The pop fails as an empty pop; the push succeeds.
- Simultaneous push and pop with 0<level<DEPTH: both happen, level unchanged.
- Full FIFO: writer_ready_o=0, so pops only.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Zero padding: result_o bits ≥ DATA_WIDTH are zero.
- Divider: counter cnt counts successful pops.
  - Pop with cnt==sample_div_i: cnt←0, status_sample_o pulses.
  - Pop otherwise: cnt+1.
  - sample_div_i=0 pulses on every pop.
  - If sample_div_i changes below cnt, the next pop has cnt>sample_div_i and must treat it as a match: pulse and cnt←0.
- Priority: rst_i > clear_i > push/pop.
- clear_i: level, pointers, cnt, overflow_o and underflow_o go to 0. result_o and spike_count_o hold. A push or pop in the same cycle is ignored.

## Timing
- Reset values: writer_ready_o=1, result_o=0, result_valid_o=0, status_sample_o=0, level_o=0, overflow_o=0, underflow_o=0, spike_count_o=0.
- Reset mid-operation discards all stored frames.
- writer_ready_o = (level != DEPTH), decoded from the level register. It deasserts in the cycle level reaches DEPTH, one cycle after the filling push.
- Pop latency: sample_i sampled at edge k gives result_o, result_valid_o, status_sample_o and spike_count_o valid in cycle k→k+1.
- Pulses last exactly one cycle.
- Flags set in the cycle after the offending edge and stay set until clear_i or rst_i.
- status_ready_o has zero latency.

## Configuration
- SPIKER_WRITER_POPCOUNT_EN defined: spike_count_o is registered with result_o and equals the number of ones in the popped frame's DATA_WIDTH bits.
- Not defined: spike_count_o is tied to 0 and no popcount logic is built.

## Structure
- Package spiker_writer_pkg holds:
  - default WORD_WIDTH and DATA_WIDTH;
  - function n_words(data_w, word_w) for N_REG;
  - popcount function;
  - level/pointer width helpers.
- Sub-module spiker_frame_fifo: DEPTH×DATA_WIDTH storage with pointers, level and full/empty.
- The top level holds the pop register, divider, flags and popcount.

## Test plan
- Reset, then idle: all outputs at reset values, writer_ready_o=1, level_o=0.
- Push frames F0..F3 (DEPTH=4), then 4 sample_i: result_o=F0..F3 in order, four result_valid_o pulses; writer_ready_o=0 while level_o=4.
- Push 5 frames without sampling: 5th frame dropped, overflow_o=1; pop 4 returns F0..F3; clear_i → overflow_o=0.
- sample_i on empty: underflow_o=1, no result_valid_o, result_o unchanged. Push and sample in the same cycle on empty: level_o=1, underflow_o=1.
- sample_div_i=14, 30 successful pops: status_sample_o pulses on pops 15 and 30 only. sample_div_i=0: pulse on every pop.
- POPCOUNT_EN: pop an all-ones 800-bit frame → spike_count_o=800; a frame with bits 0 and 799 set → 2; word 24 upper bits zero-padded when DATA_WIDTH=784.
